// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard : per-register write scoreboard with RAW/WAW issue
//                     interlock, in-flight write limit and drain/halt control.
// Revision          : 1.0
// ============================================================================
module hazard_scoreboard #(
   parameter int NUM_REGS        = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int MAX_OUTSTANDING = 4,
   localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   output logic                  id_ready_o,
   input  logic [ADDR_WIDTH-1:0] id_rs1_i,
   input  logic [ADDR_WIDTH-1:0] id_rs2_i,
   input  logic                  id_rs1_used_i,
   input  logic                  id_rs2_used_i,
   input  logic [ADDR_WIDTH-1:0] id_rd_i,
   input  logic                  id_rd_we_i,
   input  logic                  wb_valid_i,
   input  logic [ADDR_WIDTH-1:0] wb_rd_i,
   input  logic                  flush_i,
   input  logic                  drain_req_i,
   output logic                  drained_o,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic [CNT_W-1:0]      outstanding_o,
   output logic                  err_o
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [CNT_W-1:0]    out_q;
   logic [CNT_W-1:0]    out_d;
   logic                err_q;
   logic                drained_q;

   logic raw_hz;
   logic waw_hz;
   logic counts;
   logic full;
   logic issue_cnt;
   logic wb_hit;

   // Interlock looks only at registered busy bits: a retiring write frees its
   // consumer one cycle later, never in the same cycle.
   assign raw_hz    = (id_rs1_used_i && busy_q[id_rs1_i]) ||
                      (id_rs2_used_i && busy_q[id_rs2_i]);
   assign waw_hz    = id_rd_we_i && busy_q[id_rd_i];
   assign counts    = id_rd_we_i && (id_rd_i != '0);
   assign full      = (out_q == CNT_W'(MAX_OUTSTANDING));

   assign id_ready_o = (state_q == RUN) && !drain_req_i && !flush_i &&
                       !raw_hz && !waw_hz && !(counts && full);

   assign issue_cnt = id_valid_i && id_ready_o && counts;
   assign wb_hit    = wb_valid_i && busy_q[wb_rd_i];

   always_comb begin
      busy_d = busy_q;
      out_d  = out_q;
      if (flush_i) begin
         busy_d = '0;
         out_d  = '0;
      end else begin
         if (wb_hit) begin
            busy_d[wb_rd_i] = 1'b0;
         end
         if (issue_cnt) begin
            busy_d[id_rd_i] = 1'b1;
         end
         case ({issue_cnt, wb_hit})
            2'b10:   out_d = out_q + CNT_W'(1);
            2'b01:   out_d = out_q - CNT_W'(1);
            default: out_d = out_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (drain_req_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!drain_req_i) begin
               state_d = RUN;
            end else if ((out_q == '0) || flush_i) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (!drain_req_i) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= RUN;
         busy_q    <= '0;
         out_q     <= '0;
         err_q     <= 1'b0;
         drained_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         out_q     <= out_d;
         drained_q <= (state_d == HALTED);
         // A flush discards the same-cycle writeback entirely, error included.
         if (wb_valid_i && !flush_i && !wb_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign busy_o        = busy_q;
   assign outstanding_o = out_q;
   assign err_o         = err_q;
   assign drained_o     = drained_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard : directed literal checks plus randomized traffic compared
// every cycle against a set-based behavioural model of the scoreboard.
module tb_hazard_scoreboard;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int MO = 4;
   localparam int CW = $clog2(MO + 1);

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_HALT  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid;
   logic          id_ready;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic          rs1_used;
   logic          rs2_used;
   logic [AW-1:0] rd;
   logic          rd_we;
   logic          wb_valid;
   logic [AW-1:0] wb_rd;
   logic          flush;
   logic          drain_req;
   logic          drained;
   logic [NR-1:0] busy;
   logic [CW-1:0] outstanding;
   logic          err;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .NUM_REGS        (NR),
      .ADDR_WIDTH      (AW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .id_valid_i    (id_valid),
      .id_ready_o    (id_ready),
      .id_rs1_i      (rs1),
      .id_rs2_i      (rs2),
      .id_rs1_used_i (rs1_used),
      .id_rs2_used_i (rs2_used),
      .id_rd_i       (rd),
      .id_rd_we_i    (rd_we),
      .wb_valid_i    (wb_valid),
      .wb_rd_i       (wb_rd),
      .flush_i       (flush),
      .drain_req_i   (drain_req),
      .drained_o     (drained),
      .busy_o        (busy),
      .outstanding_o (outstanding),
      .err_o         (err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // Model: the set of registers with a write in flight, a sticky error and a mode.
   int pending[$];
   bit m_err  = 1'b0;
   int m_mode = M_RUN;

   function automatic bit m_busy(int r);
      foreach (pending[i]) if (pending[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [NR-1:0] m_busy_vec();
      logic [NR-1:0] v;
      v = '0;
      foreach (pending[i]) v[pending[i]] = 1'b1;
      return v;
   endfunction

   function automatic bit m_ready();
      if (m_mode != M_RUN || drain_req || flush) return 1'b0;
      if (rs1_used && m_busy(int'(rs1))) return 1'b0;
      if (rs2_used && m_busy(int'(rs2))) return 1'b0;
      if (rd_we && m_busy(int'(rd))) return 1'b0;
      if (rd_we && rd != 0 && pending.size() == MO) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge rst) begin : model_step
      bit iss;
      int nmode;
      int k;
      if (rst) begin
         pending.delete();
         m_err  = 1'b0;
         m_mode = M_RUN;
      end else begin
         iss   = id_valid && m_ready();
         nmode = m_mode;
         case (m_mode)
            M_RUN:   if (drain_req) nmode = M_DRAIN;
            M_DRAIN: if (!drain_req) nmode = M_RUN;
                     else if (pending.size() == 0 || flush) nmode = M_HALT;
            default: if (!drain_req) nmode = M_RUN;
         endcase
         if (flush) begin
            pending.delete();
         end else begin
            if (wb_valid) begin
               k = -1;
               foreach (pending[i]) if (pending[i] == int'(wb_rd)) k = i;
               if (k >= 0) pending.delete(k);
               else m_err = 1'b1;
            end
            if (iss && rd_we && rd != 0) pending.push_back(int'(rd));
         end
         m_mode = nmode;
      end
   end

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_ready",       64'(id_ready),    64'(m_ready()));
         check("model_busy",        64'(busy),        64'(m_busy_vec()));
         check("model_outstanding", 64'(outstanding), 64'(pending.size()));
         check("model_err",         64'(err),         64'(m_err));
         check("model_drained",     64'(drained),     64'(m_mode == M_HALT));
      end
   end

   task automatic idle_in();
      id_valid = 1'b0; rs1 = '0; rs2 = '0; rs1_used = 1'b0; rs2_used = 1'b0;
      rd = '0; rd_we = 1'b0; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   initial begin
      idle_in();
      drain_req = 1'b0;
      rst       = 1'b1;
      chk_en    = 1'b1;
      #2;
      check("reset_busy",    64'(busy),        64'd0);
      check("reset_out",     64'(outstanding), 64'd0);
      check("reset_err",     64'(err),         64'd0);
      check("reset_drained", 64'(drained),     64'd0);
      tick(); tick();
      rst = 1'b0;

      // RAW stall on rd=5, released the cycle after its writeback
      tick(); id_valid = 1'b1; rd = 5'd5; rd_we = 1'b1;
      at_neg(); check("raw_first_issue", 64'(id_ready), 64'd1);
      tick(); rd_we = 1'b0; rd = '0; rs1 = 5'd5; rs1_used = 1'b1;
      at_neg(); check("raw_stall", 64'(id_ready), 64'd0);
      check("raw_busy5", 64'(busy[5]), 64'd1);
      tick(); wb_valid = 1'b1; wb_rd = 5'd5;
      at_neg(); check("raw_no_bypass", 64'(id_ready), 64'd0);
      tick(); wb_valid = 1'b0;
      at_neg(); check("raw_release", 64'(id_ready), 64'd1);
      tick(); idle_in();

      // Fill to the in-flight limit
      for (int i = 1; i <= 4; i++) begin
         tick(); id_valid = 1'b1; rd_we = 1'b1; rd = AW'(i);
      end
      tick(); rd = 5'd6;
      at_neg(); check("full_out", 64'(outstanding), 64'd4);
      check("full_stall", 64'(id_ready), 64'd0);
      tick(); rd_we = 1'b0;
      at_neg(); check("full_nowrite_issue", 64'(id_ready), 64'd1);

      // Simultaneous counted issue and writeback
      tick(); idle_in(); wb_valid = 1'b1; wb_rd = 5'd1;
      tick(); wb_rd = 5'd2;
      tick(); wb_rd = 5'd3; id_valid = 1'b1; rd_we = 1'b1; rd = 5'd7;
      at_neg(); check("simul_pre_out", 64'(outstanding), 64'd2);
      check("simul_ready", 64'(id_ready), 64'd1);
      tick(); idle_in();
      at_neg(); check("simul_out", 64'(outstanding), 64'd2);
      check("simul_busy7", 64'(busy[7]), 64'd1);
      check("simul_busy3", 64'(busy[3]), 64'd0);

      // Flush with concurrent writeback
      tick(); id_valid = 1'b1; rd_we = 1'b1; rd = 5'd2;
      tick(); idle_in();
      at_neg(); check("flush_pre_out", 64'(outstanding), 64'd3);
      tick(); flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd2; id_valid = 1'b1; rd_we = 1'b1; rd = 5'd8;
      at_neg(); check("flush_block", 64'(id_ready), 64'd0);
      tick(); idle_in();
      at_neg(); check("flush_busy", 64'(busy), 64'd0);
      check("flush_out", 64'(outstanding), 64'd0);
      check("flush_err", 64'(err), 64'd0);

      // Drain / halt / resume
      tick(); id_valid = 1'b1; rd_we = 1'b1; rd = 5'd10;
      tick(); rd = 5'd11;
      tick(); idle_in(); drain_req = 1'b1; id_valid = 1'b1;
      at_neg(); check("drain_out", 64'(outstanding), 64'd2);
      check("drain_block", 64'(id_ready), 64'd0);
      check("drain_not_yet", 64'(drained), 64'd0);
      tick(); id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd10;
      tick(); wb_rd = 5'd11;
      tick(); wb_valid = 1'b0;
      at_neg(); check("drain_empty_out", 64'(outstanding), 64'd0);
      check("drain_empty_not_halt", 64'(drained), 64'd0);
      tick();
      at_neg(); check("drain_halted", 64'(drained), 64'd1);
      tick(); drain_req = 1'b0; id_valid = 1'b1;
      at_neg(); check("resume_still_halt", 64'(drained), 64'd1);
      check("resume_block", 64'(id_ready), 64'd0);
      tick();
      at_neg(); check("resume_run", 64'(drained), 64'd0);
      check("resume_ready", 64'(id_ready), 64'd1);
      tick(); idle_in();

      // Sticky error, then asynchronous reset between edges
      tick(); wb_valid = 1'b1; wb_rd = 5'd9;
      tick(); wb_valid = 1'b0; id_valid = 1'b1; rd_we = 1'b1; rd = 5'd12;
      at_neg(); check("err_set", 64'(err), 64'd1);
      tick(); id_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd12;
      tick(); idle_in(); id_valid = 1'b1; rd_we = 1'b1; rd = 5'd13;
      at_neg(); check("err_sticky", 64'(err), 64'd1);
      tick(); idle_in();
      at_neg(); check("pre_rst_busy13", 64'(busy[13]), 64'd1);
      #2; rst = 1'b1;
      #1; check("async_rst_err", 64'(err), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_out", 64'(outstanding), 64'd0);
      id_valid = 1'b1; rd_we = 1'b1; rd = 5'd14;
      #1; check("rst_ready", 64'(id_ready), 64'd1);
      tick();
      at_neg(); check("rst_hold_busy", 64'(busy), 64'd0);
      tick(); rst = 1'b0; idle_in();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         tick();
         rst      = ($urandom_range(0, 199) == 0);
         id_valid = ($urandom_range(0, 9) < 7);
         rs1      = AW'($urandom_range(0, 15));
         rs2      = AW'($urandom_range(0, 15));
         rs1_used = ($urandom_range(0, 1) == 1);
         rs2_used = ($urandom_range(0, 1) == 1);
         rd       = AW'($urandom_range(0, 15));
         rd_we    = ($urandom_range(0, 9) < 6);
         wb_valid = ($urandom_range(0, 9) < 4);
         if (pending.size() > 0 && $urandom_range(0, 9) != 0)
            wb_rd = AW'(pending[$urandom_range(0, pending.size() - 1)]);
         else
            wb_rd = AW'($urandom_range(0, 15));
         flush    = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 29) == 0) drain_req = ~drain_req;
      end
      tick(); idle_in(); rst = 1'b0; drain_req = 1'b0;
      tick(); tick();
      at_neg();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
